multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have port `reset`: input, 1 bit, synchronous and active-low; `reset`=0 sampled at a rising `clk` edge resets the block.
REQ-003 The block SHALL have port `Op`: input, 11 bits, instruction[31:21] as held in the instruction register.
REQ-004 The block SHALL have port `zero`: input, 1 bit, ALU zero flag.
REQ-005 The block SHALL have port `mem_ready`: input, 1 bit, memory completes the current read or write this cycle.
REQ-006 The block SHALL have outputs `PCWrite`, `IRWrite`, `IorD`, `Reg2Loc`, `ALUSrcA`, `MemRead`, `MemWrite`, `MemtoReg`, `RegWrite`, `PCSrc`, each 1 bit.
REQ-007 The block SHALL have outputs `ALUSrcB` and `ALUOp`, each 2 bits.
REQ-008 The block SHALL have output `illegal`: 1 bit, one-cycle pulse when the decoded opcode is unsupported.
REQ-009 The block SHALL have output `state_o`: 4 bits, current state encoding, for debug.

Function
REQ-010 Opcode classes SHALL be:
- LDUR = 111_1100_0010
- STUR = 111_1100_0000
- CBZ = 101_1010_0xxx
- R-type = ADD 100_0101_1000, SUB 110_0101_1000, AND 100_0101_0000, ORR 101_0101_0000
- all other codes are illegal.
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, CBZS.
REQ-012 Outputs SHALL be Moore outputs of the state only, except the `mem_ready`-qualified `PCWrite`/`IRWrite` in FETCH and the `zero`-qualified `PCWrite` in CBZS.
REQ-013 Any output not listed for a state SHALL be 0.
REQ-014 FETCH SHALL drive:
- `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00
- `IRWrite`=`PCWrite`=`mem_ready`.
REQ-015 FETCH SHALL go to DECODE if `mem_ready`, else remain in FETCH (wait states unbounded).
REQ-016 DECODE SHALL drive `Reg2Loc`=1 for STUR/CBZ and 0 otherwise.
REQ-017 DECODE SHALL transition: LDUR/STUR -> MEMADR; R-type -> EXEC; CBZ -> CBZS; illegal -> FETCH with `illegal`=1 for exactly that cycle.
REQ-018 MEMADR SHALL drive `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00, and go to MEMRD for LDUR or MEMWR for STUR.
REQ-019 MEMRD SHALL drive `MemRead`=1 and `IorD`=1, and go to MEMWB on `mem_ready`, else hold.
REQ-020 MEMWB SHALL drive `RegWrite`=1 and `MemtoReg`=1, then go to FETCH.
REQ-021 MEMWR SHALL drive `MemWrite`=1, `IorD`=1 and `Reg2Loc`=1, and go to FETCH on `mem_ready`, else hold.
REQ-022 EXEC SHALL drive `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10, then go to ALUWB.
REQ-023 ALUWB SHALL drive `RegWrite`=1 and `MemtoReg`=0, then go to FETCH.
REQ-024 CBZS SHALL drive `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `Reg2Loc`=1, `PCSrc`=1, `PCWrite`=`zero`, then go to FETCH.
REQ-025 Latency with no wait states SHALL be: CBZ 3 cycles, R-type 4, STUR 4, LDUR 5, illegal 2.
REQ-026 `Op` SHALL be sampled only in DECODE, MEMADR and CBZS; changes to `Op` in other states SHALL have no effect.
REQ-027 `mem_ready` outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-028 At most one of `MemRead` and `MemWrite` SHALL be 1 in any cycle.
REQ-029 `RegWrite` and `MemWrite` SHALL never be 1 in the same cycle.
REQ-030 An unreachable state encoding SHALL go to FETCH on the next edge with all outputs 0.

Reset
REQ-031 `reset`=0 at a rising edge SHALL force state FETCH and take precedence over every transition, including mid-wait in MEMRD or MEMWR.
REQ-032 While `reset`=0, all outputs SHALL be 0, including `PCWrite`, `IRWrite`, `MemRead` and `illegal`.
REQ-033 After `reset`=0 is sampled, `state_o` SHALL read FETCH.
REQ-034 The first FETCH SHALL begin in the cycle after `reset` returns to 1.

Structure
REQ-035 Package `multicycle_pkg` SHALL hold the state enum (4-bit), the opcode constants, and the `ALUSrcB`/`ALUOp` encodings.
REQ-036 Combinational sub-module `opclass` SHALL map `Op` to {LD, ST, CB, RT, ILL}.
REQ-037 `multicycle_ctrl` SHALL contain only the state register, the next-state logic and the output logic.

Verification
REQ-038 The bench SHALL run, with `mem_ready`=1, `reset` low for 2 cycles, then `Op`=111_1100_0010 (LDUR), and see states FETCH, DECODE, MEMADR, MEMRD, MEMWB, with `RegWrite`=`MemtoReg`=1 in cycle 5.
REQ-039 The bench SHALL run STUR (111_1100_0000) with `mem_ready` low for 3 cycles in MEMWR, and see `MemWrite` held 4 cycles, `RegWrite`=0 throughout, then FETCH.
REQ-040 The bench SHALL run CBZ (101_1010_0101) with `zero`=1, seeing `PCWrite`=`PCSrc`=1 in CBZS, then repeat with `zero`=0, seeing `PCWrite`=0.
REQ-041 The bench SHALL run ADD (100_0101_1000) and see `ALUOp`=10 in EXEC, `RegWrite`=1 with `MemtoReg`=0 in ALUWB, 4 cycles total.
REQ-042 The bench SHALL present `Op`=000_0000_0000 and see `illegal`=1 for one cycle in DECODE, then FETCH, with no `RegWrite` or `MemWrite`.
REQ-043 The bench SHALL assert `reset`=0 during a MEMRD wait and see FETCH with all outputs 0 at the next edge, then a normal fetch after release.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle LEGv8-style control unit: state
// encoding, opcode constants, ALU operand/operation encodings and the
// control-word bundle driven by the FSM.
package multicycle_pkg;

  // FETCH is deliberately encoded as zero so that a forced-idle state_o and
  // "all outputs zero" describe the same thing.
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    CBZS   = 4'd8
  } state_e;

  // Instruction classes produced by the opcode classifier.
  typedef enum logic [2:0] {
    OP_LD  = 3'd0,
    OP_ST  = 3'd1,
    OP_CB  = 3'd2,
    OP_RT  = 3'd3,
    OP_ILL = 3'd4
  } op_class_e;

  // Opcode field instruction[31:21].
  localparam logic [10:0] OPC_LDUR     = 11'b111_1100_0010;
  localparam logic [10:0] OPC_STUR     = 11'b111_1100_0000;
  localparam logic [10:0] OPC_ADD      = 11'b100_0101_1000;
  localparam logic [10:0] OPC_SUB      = 11'b110_0101_1000;
  localparam logic [10:0] OPC_AND      = 11'b100_0101_0000;
  localparam logic [10:0] OPC_ORR      = 11'b101_0101_0000;
  // CBZ only fixes the upper eight bits; the low three are don't-care.
  localparam logic [10:0] OPC_CBZ      = 11'b101_1010_0000;
  localparam logic [10:0] OPC_CBZ_MASK = 11'b111_1111_1000;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_REG  = 2'b00;  // register read data 2
  localparam logic [1:0] SRCB_FOUR = 2'b01;  // constant 4 for PC increment
  localparam logic [1:0] SRCB_IMM  = 2'b10;  // sign-extended offset

  // ALU operation class handed to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // address / PC arithmetic
  localparam logic [1:0] ALUOP_PASSB = 2'b01;  // pass B for the zero test
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // use the funct bits

  // Complete control word; every field defaults to zero.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       ior_d;
    logic       reg2loc;
    logic       alu_src_a;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_src;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/multicycle_ctrl_opclass.sv
// Purely combinational opcode classifier: maps instruction[31:21] onto one
// of the five instruction classes the control FSM distinguishes.
module opclass
  import multicycle_pkg::*;
(
  input  logic [10:0] op_i,
  output op_class_e   class_o
);

  // Exact-match decode; anything not recognised is flagged illegal.
  // NOTE: class_o is given a value before any branch so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    class_o = OP_ILL;
    if (op_i == OPC_LDUR) begin
      class_o = OP_LD;
    end else if (op_i == OPC_STUR) begin
      class_o = OP_ST;
    end else if ((op_i & OPC_CBZ_MASK) == OPC_CBZ) begin
      class_o = OP_CB;
    end else if (op_i inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR}) begin
      class_o = OP_RT;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller. A single FSM sequences fetch, decode and
// the per-class execute/memory/write-back steps. Outputs are a function of
// the state, except the mem_ready-qualified fetch strobes and the
// zero-qualified branch PC write. Reset is synchronous and active-low.
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        Reg2Loc,
  output logic        ALUSrcA,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        illegal,
  output logic [3:0]  state_o
);

  state_e    state_q;
  state_e    state_d;
  op_class_e op_class;
  ctrl_t     ctrl;

  opclass u_opclass (
    .op_i    (Op),
    .class_o (op_class)
  );

  // State register: reset forces FETCH and overrides any pending transition.
  // NOTE: reset appears only inside the clocked branch, so it is sampled on the edge (synchronous); adding it to the sensitivity list would make it asynchronous.
  // NOTE: non-blocking assignment keeps every register update on the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control-word decode; reset forces the whole word to zero.
  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_IDLE;

    case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ior_d     = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        // Only latch the instruction and advance the PC once memory delivers.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = DECODE;
        end
      end

      DECODE: begin
        // Stores and CBZ read Rt through the second register port.
        ctrl.reg2loc = (op_class == OP_ST) || (op_class == OP_CB);
        case (op_class)
          OP_LD, OP_ST: state_d = MEMADR;
          OP_RT:        state_d = EXEC;
          OP_CB:        state_d = CBZS;
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = FETCH;
          end
        endcase
      end

      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        // Op is re-sampled here; a class that is neither load nor store
        // can only arise if Op was disturbed, so abandon the instruction.
        if (op_class == OP_LD) begin
          state_d = MEMRD;
        end else if (op_class == OP_ST) begin
          state_d = MEMWR;
        end else begin
          state_d = FETCH;
        end
      end

      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
        if (mem_ready) begin
          state_d = MEMWB;
        end
      end

      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = FETCH;
      end

      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
        ctrl.reg2loc   = 1'b1;
        if (mem_ready) begin
          state_d = FETCH;
        end
      end

      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_RTYPE;
        state_d        = ALUWB;
      end

      ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        state_d         = FETCH;
      end

      CBZS: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_PASSB;
        ctrl.reg2loc   = 1'b1;
        ctrl.pc_src    = 1'b1;
        ctrl.pc_write  = zero;
        state_d        = FETCH;
      end

      // Unused encodings recover to FETCH with the idle control word.
      default: begin
        state_d = FETCH;
      end
    endcase

    if (!reset) begin
      ctrl = CTRL_IDLE;
    end
  end

  assign PCWrite  = ctrl.pc_write;
  assign IRWrite  = ctrl.ir_write;
  assign IorD     = ctrl.ior_d;
  assign Reg2Loc  = ctrl.reg2loc;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign PCSrc    = ctrl.pc_src;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign illegal  = ctrl.illegal;

  // While reset is held the debug port reads FETCH (all zeros).
  assign state_o  = reset ? state_q : FETCH;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed instruction scenarios with
// hand-computed expectations, followed by randomized traffic checked every
// cycle against an instruction-level reference model.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  // Bit positions inside the packed control vector used by the bench.
  localparam int B_PCW   = 14;
  localparam int B_IRW   = 13;
  localparam int B_IORD  = 12;
  localparam int B_R2L   = 11;
  localparam int B_SRCA  = 10;
  localparam int B_MRD   = 9;
  localparam int B_MWR   = 8;
  localparam int B_M2R   = 7;
  localparam int B_RW    = 6;
  localparam int B_PCSRC = 5;
  localparam int B_SRCB  = 3;   // 2 bits
  localparam int B_ALUOP = 1;   // 2 bits
  localparam int B_ILL   = 0;

  typedef enum logic [2:0] {K_LD, K_ST, K_CB, K_RT, K_ILL} kind_t;

  logic        clk;
  logic        reset;
  logic [10:0] Op;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, IRWrite, IorD, Reg2Loc, ALUSrcA, MemRead;
  logic        MemWrite, MemtoReg, RegWrite, PCSrc, illegal;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state_o;
  logic [14:0] dut_ctrl;

  int n_vec  = 0;
  int n_miss = 0;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .IRWrite   (IRWrite),
    .IorD      (IorD),
    .Reg2Loc   (Reg2Loc),
    .ALUSrcA   (ALUSrcA),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .PCSrc     (PCSrc),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .illegal   (illegal),
    .state_o   (state_o)
  );

  assign dut_ctrl = {PCWrite, IRWrite, IorD, Reg2Loc, ALUSrcA, MemRead, MemWrite,
                     MemtoReg, RegWrite, PCSrc, ALUSrcB, ALUOp, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic kind_t classify(input logic [10:0] op);
    casez (op)
      11'b111_1100_0010: return K_LD;
      11'b111_1100_0000: return K_ST;
      11'b101_1010_0???: return K_CB;
      11'b100_0101_1000,
      11'b110_0101_1000,
      11'b100_0101_0000,
      11'b101_0101_0000: return K_RT;
      default:           return K_ILL;
    endcase
  endfunction

  // Steps an instruction visits after DECODE, as a table; FETCH ends it.
  function automatic state_e path_at(input kind_t k, input int idx);
    state_e p[3];
    p = '{FETCH, FETCH, FETCH};
    case (k)
      K_LD: p = '{MEMADR, MEMRD, MEMWB};
      K_ST: p = '{MEMADR, MEMWR, FETCH};
      K_RT: p = '{EXEC, ALUWB, FETCH};
      K_CB: p = '{CBZS, FETCH, FETCH};
      default: p = '{FETCH, FETCH, FETCH};
    endcase
    return (idx < 3) ? p[idx] : FETCH;
  endfunction

  // Control word each step must present.
  function automatic logic [14:0] exp_ctrl(input state_e s, input logic mr,
                                           input logic z, input logic [10:0] op);
    logic [14:0] e;
    kind_t k;
    e = '0;
    k = classify(op);
    case (s)
      FETCH:  begin e[B_MRD] = 1'b1; e[B_SRCB +: 2] = 2'b01; e[B_PCW] = mr; e[B_IRW] = mr; end
      DECODE: begin e[B_R2L] = (k == K_ST) || (k == K_CB); e[B_ILL] = (k == K_ILL); end
      MEMADR: begin e[B_SRCA] = 1'b1; e[B_SRCB +: 2] = 2'b10; end
      MEMRD:  begin e[B_MRD] = 1'b1; e[B_IORD] = 1'b1; end
      MEMWB:  begin e[B_RW] = 1'b1; e[B_M2R] = 1'b1; end
      MEMWR:  begin e[B_MWR] = 1'b1; e[B_IORD] = 1'b1; e[B_R2L] = 1'b1; end
      EXEC:   begin e[B_SRCA] = 1'b1; e[B_ALUOP +: 2] = 2'b10; end
      ALUWB:  begin e[B_RW] = 1'b1; end
      CBZS:   begin e[B_SRCA] = 1'b1; e[B_ALUOP +: 2] = 2'b01; e[B_R2L] = 1'b1;
                    e[B_PCSRC] = 1'b1; e[B_PCW] = z; end
      default: e = '0;
    endcase
    return e;
  endfunction

  state_e model_step = FETCH;
  kind_t  model_kind = K_ILL;
  int     model_idx  = 0;

  // Model advance: waits hold on !mem_ready, otherwise walk the class path.
  always @(posedge clk) begin
    if (!reset) begin
      model_step <= FETCH;
    end else if ((model_step == FETCH || model_step == MEMRD || model_step == MEMWR) && !mem_ready) begin
      model_step <= model_step;
    end else if (model_step == FETCH) begin
      model_step <= DECODE;
    end else if (model_step == DECODE) begin
      model_kind <= classify(Op);
      model_idx  <= 1;
      model_step <= path_at(classify(Op), 0);
    end else begin
      model_step <= path_at(model_kind, model_idx);
      model_idx  <= model_idx + 1;
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    check("model_ctrl", 32'(dut_ctrl), reset ? 32'(exp_ctrl(model_step, mem_ready, zero, Op)) : 32'd0);
    check("model_state", 32'(state_o), reset ? 32'(model_step) : 32'(FETCH));
    if (MemRead && MemWrite) check("rd_wr_exclusive", 32'd1, 32'd0);
    if (RegWrite && MemWrite) check("rw_mw_exclusive", 32'd1, 32'd0);
  end

  // ---------------- stimulus ----------------
  logic [14:0] obs_ctrl [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles from FETCH with Op held, mem_ready per cycle from mr_pat,
  // and checks state_o against the hand-written sequence (4 bits per cycle).
  task automatic run_instr(input string tag, input logic [10:0] op, input logic z,
                           input logic [15:0] mr_pat, input int n, input logic [63:0] exp_st);
    Op   = op;
    zero = z;
    for (int i = 0; i < n; i++) begin
      mem_ready = mr_pat[i];
      @(negedge clk);
      obs_ctrl[i] = dut_ctrl;
      check({tag, "_state"}, 32'(state_o), 32'(exp_st[4*i +: 4]));
      tick();
    end
  endtask

  function automatic logic [10:0] rand_op();
    case ($urandom_range(0, 7))
      0: return OPC_LDUR;
      1: return OPC_STUR;
      2: return {8'b1011_0100, 3'($urandom_range(0, 7))};
      3: return OPC_ADD;
      4: return OPC_SUB;
      5: return OPC_AND;
      6: return OPC_ORR;
      default: return 11'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic any_w;

    reset = 1'b0; Op = '0; zero = 1'b0; mem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("reset_outs", 32'(dut_ctrl), 32'd0);
    check("reset_state", 32'(state_o), 32'd0);
    tick();
    reset = 1'b1;

    // LDUR without waits: F D MA MR WB.
    run_instr("ldur", OPC_LDUR, 1'b0, 16'hffff, 5, 64'({MEMWB, MEMRD, MEMADR, DECODE, FETCH}));
    check("ldur_wb", {obs_ctrl[4][B_RW], obs_ctrl[4][B_M2R]}, 2'b11);
    check("ldur_fetch_strobes", {obs_ctrl[0][B_PCW], obs_ctrl[0][B_IRW], obs_ctrl[0][B_MRD]}, 3'b111);

    // STUR with three wait cycles in MEMWR.
    run_instr("stur", OPC_STUR, 1'b0, 16'b1111_1111_1100_0111, 7,
              64'({MEMWR, MEMWR, MEMWR, MEMWR, MEMADR, DECODE, FETCH}));
    cnt = 0; any_w = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cnt += int'(obs_ctrl[i][B_MWR]);
      any_w |= obs_ctrl[i][B_RW];
    end
    check("stur_memwrite_cycles", 32'(cnt), 32'd4);
    check("stur_no_regwrite", 32'(any_w), 32'd0);

    // CBZ taken and not taken.
    run_instr("cbz_t", 11'b101_1010_0101, 1'b1, 16'hffff, 3, 64'({CBZS, DECODE, FETCH}));
    check("cbz_taken", {obs_ctrl[2][B_PCW], obs_ctrl[2][B_PCSRC]}, 2'b11);
    run_instr("cbz_n", 11'b101_1010_0101, 1'b0, 16'hffff, 3, 64'({CBZS, DECODE, FETCH}));
    check("cbz_not_taken", {obs_ctrl[2][B_PCW], obs_ctrl[2][B_PCSRC]}, 2'b01);

    // ADD: 4 cycles.
    run_instr("add", OPC_ADD, 1'b0, 16'hffff, 4, 64'({ALUWB, EXEC, DECODE, FETCH}));
    check("add_aluop", 32'(obs_ctrl[2][B_ALUOP +: 2]), 32'd2);
    check("add_wb", {obs_ctrl[3][B_RW], obs_ctrl[3][B_M2R]}, 2'b10);

    // Illegal opcode: one-cycle pulse, back to FETCH.
    run_instr("ill", 11'b000_0000_0000, 1'b0, 16'hffff, 2, 64'({DECODE, FETCH}));
    check("ill_pulse", {obs_ctrl[0][B_ILL], obs_ctrl[1][B_ILL]}, 2'b01);
    check("ill_no_write", {obs_ctrl[0][B_RW] | obs_ctrl[1][B_RW], obs_ctrl[0][B_MWR] | obs_ctrl[1][B_MWR]}, 2'b00);

    // Reset in the middle of a MEMRD wait.
    run_instr("ldwait", OPC_LDUR, 1'b0, 16'b0000_0000_0000_0111, 5,
              64'({MEMRD, MEMRD, MEMADR, DECODE, FETCH}));
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", 32'(dut_ctrl), 32'd0);
    tick();
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("rst_fetch_state", 32'(state_o), 32'(FETCH));
    check("rst_fetch_ctrl", 32'(dut_ctrl), 32'h6208);
    tick();
    @(negedge clk);
    check("rst_decode_state", 32'(state_o), 32'(DECODE));
    tick();

    // Randomized traffic; Op only moves while the DUT is not sampling it.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 63) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      zero      = 1'($urandom_range(0, 1));
      if (!(model_step inside {DECODE, MEMADR, CBZS})) Op = rand_op();
      tick();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
